apu_rr_dispatcher: RTL and testbench
====================================

Name: apu_rr_dispatcher

Overview:
- Shared-APU front end: arbitrates FP requests from NCORES cores onto one shared fixed-latency FP unit, e.g. addsub with PIPE_REGS=1 or div with PIPE_REGS=3.
- Tracks every accepted operation through a tag pipeline so each result is routed back to the core that issued it.
- Sits directly upstream of one shared unit instance. One dispatcher per non-private unit type.

Parameters:
- NCORES, 8, number of requesting cores (>=2).
- WOP, 1, unit opcode width (WOP_ADDSUB etc.).
- NARGS, 2, operands per operation.
- WDATA, 32, operand/result width (FP_WIDTH).
- NDSFLAGS, 3, downstream flag width.
- NUSFLAGS, 8, upstream flag width.
- WTAG, 2, core-side tag width.
- PIPE_REGS, 1, unit latency in cycles, >=1; elaboration error if 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- core_req_i  in  NCORES  per-core request
- core_gnt_o  out  NCORES  one-hot grant, same cycle as request
- core_op_i  in  NCORES*WOP  per-core opcode
- core_args_i  in  NCORES*NARGS*WDATA  per-core operands, core c at slice c
- core_flags_i  in  NCORES*NDSFLAGS  per-core rounding/flags
- core_tag_i  in  NCORES*WTAG  per-core tag
- core_rvalid_o  out  NCORES  one-hot result valid
- core_result_o  out  WDATA  result, broadcast to all cores
- core_flags_o  out  NUSFLAGS  status flags, broadcast
- core_rtag_o  out  WTAG  tag of returned result
- unit_valid_o  out  1  operation issued to unit
- unit_op_o  out  WOP  muxed opcode
- unit_args_o  out  NARGS*WDATA  muxed operands
- unit_flags_o  out  NDSFLAGS  muxed flags
- unit_result_i  in  WDATA  unit result, PIPE_REGS cycles after issue
- unit_flags_i  in  NUSFLAGS  unit status
- inflight_o  out  clog2(PIPE_REGS+1)  number of operations in flight
- contention_cnt_o  out  32  see Optional Feature

Behaviour:
- Arbitration is combinational round-robin with priority pointer ptr (clog2(NCORES) bits).
- Winner is the first requesting core at index ptr, ptr+1, … modulo NCORES.
- At most one core_gnt_o bit is set per cycle, and only if that core's core_req_i is high.
- unit_valid_o = |core_req_i. unit_op_o/args/flags come from the winner's slice; they are all-zero when there is no request.
- On a grant, ptr <= winner+1, wrapping from NCORES-1 to 0. With no request, ptr holds.
- The unit never back-pressures, so every request is granted in the cycle it is presented.
- A core holding core_req_i high is granted again only when its round-robin turn comes.
- Tag pipeline has PIPE_REGS stages, each holding {valid, core index, tag}.
- Stage 0 is loaded on grant; each stage shifts every cycle.
- Output stage drives core_rvalid_o[idx] and core_rtag_o, aligned with unit_result_i/unit_flags_i. core_result_o = unit_result_i and core_flags_o = unit_flags_i, passed combinationally.
- Latency: grant in cycle t, then core_rvalid_o in cycle t+PIPE_REGS. Throughput is 1 op/cycle.
- inflight_o counts valid pipeline stages, including the output stage. Maximum value is PIPE_REGS.
- Reset: ptr=0 and all pipeline stages invalid, so core_rvalid_o=0, core_rtag_o=0, inflight_o=0, contention_cnt_o=0.
- Reset mid-operation discards all in-flight results; no rvalid appears for them afterwards.
- Requests asserted during reset get no grant: core_gnt_o=0 and unit_valid_o=0 while rst_i=1.
- A grant and a result return in the same cycle are independent and are both honoured.

Optional Feature:
- Macro APU_DISP_CONTENTION_EN.
- Defined: contention_cnt_o increments by 1 each cycle in which ≥2 core_req_i bits are high. It saturates at 32'hFFFFFFFF and is cleared by rst_i.
- Undefined: no counter logic; contention_cnt_o is tied to 0. The port list is identical in both builds.

Test Plan:
- Single requester: NCORES=8, PIPE_REGS=1, core 3 requests once with tag 2'b10, args 3F800000/40000000. Expected: gnt[3] same cycle; rvalid[3]=1 with rtag=2'b10 one cycle later; inflight_o=1 in between.
- All 8 cores request continuously from reset. Expected: grants in order 0,1,…,7,0; each core granted exactly once per 8 cycles.
- Pointer wrap: ptr=7, cores 7 and 0 request, core 7 drops after its grant. Expected: gnt[7], then gnt[0], then ptr=1.
- PIPE_REGS=3, back-to-back grants to cores 1, 5, 2 in cycles t..t+2. Expected: rvalid[1], rvalid[5], rvalid[2] at t+3..t+5 with matching tags; inflight_o reaches 3.
- Reset mid-flight: PIPE_REGS=3, grant at t, rst_i=1 at t+1. Expected: no rvalid at t+3; all outputs at their reset values.
- APU_DISP_CONTENTION_EN: 2 cores request for 10 cycles, then 1 core for 5 cycles. Expected: contention_cnt_o=10. With the macro undefined: contention_cnt_o stays 0.

Source files
------------

// File: rtl/apu_rr_dispatcher.sv
// apu_rr_dispatcher: round-robin front end for one shared fixed-latency FP unit.
// Grants one core per cycle, forwards its operands, and routes each result back
// to the issuing core through a tag pipeline.
// Optional build macro APU_DISP_CONTENTION_EN enables the contention counter;
// without it contention_cnt_o is tied to zero.
module apu_rr_dispatcher #(
  parameter int NCORES    = 8,
  parameter int WOP       = 1,
  parameter int NARGS     = 2,
  parameter int WDATA     = 32,
  parameter int NDSFLAGS  = 3,
  parameter int NUSFLAGS  = 8,
  parameter int WTAG      = 2,
  parameter int PIPE_REGS = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NCORES-1:0]              core_req_i,
  output logic [NCORES-1:0]              core_gnt_o,
  input  logic [NCORES*WOP-1:0]          core_op_i,
  input  logic [NCORES*NARGS*WDATA-1:0]  core_args_i,
  input  logic [NCORES*NDSFLAGS-1:0]     core_flags_i,
  input  logic [NCORES*WTAG-1:0]         core_tag_i,
  output logic [NCORES-1:0]              core_rvalid_o,
  output logic [WDATA-1:0]               core_result_o,
  output logic [NUSFLAGS-1:0]            core_flags_o,
  output logic [WTAG-1:0]                core_rtag_o,
  output logic                           unit_valid_o,
  output logic [WOP-1:0]                 unit_op_o,
  output logic [NARGS*WDATA-1:0]         unit_args_o,
  output logic [NDSFLAGS-1:0]            unit_flags_o,
  input  logic [WDATA-1:0]               unit_result_i,
  input  logic [NUSFLAGS-1:0]            unit_flags_i,
  output logic [$clog2(PIPE_REGS+1)-1:0] inflight_o,
  output logic [31:0]                    contention_cnt_o
);

  localparam int IDX_W = $clog2(NCORES);
  localparam int CNT_W = $clog2(PIPE_REGS+1);
  localparam int ARG_W = NARGS*WDATA;

  if (PIPE_REGS < 1) begin : g_bad_pipe
    $error("apu_rr_dispatcher: PIPE_REGS must be >= 1");
  end
  if (NCORES < 2) begin : g_bad_ncores
    $error("apu_rr_dispatcher: NCORES must be >= 2");
  end

  // One tag-pipeline stage: which core issued the op and the tag it supplied.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic [WTAG-1:0]  tag;
  } stage_t;

  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_vld;
  logic [WTAG-1:0]        win_tag;
  stage_t [PIPE_REGS-1:0] pipe_q, pipe_d;
  stage_t                 out_stg;

  // Round-robin search: first requester at ptr, ptr+1, ... (mod NCORES); none in reset.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NCORES; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NCORES);
      if (!win_vld && core_req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    if (rst_i) win_vld = 1'b0;
  end

  // Grant decode and operand mux from the winner's slice; all-zero when idle.
  always_comb begin
    core_gnt_o   = '0;
    unit_op_o    = '0;
    unit_args_o  = '0;
    unit_flags_o = '0;
    win_tag      = '0;
    for (int c = 0; c < NCORES; c++) begin
      if (win_vld && win_idx == IDX_W'(c)) begin
        core_gnt_o[c] = 1'b1;
        unit_op_o     = core_op_i[c*WOP +: WOP];
        unit_args_o   = core_args_i[c*ARG_W +: ARG_W];
        unit_flags_o  = core_flags_i[c*NDSFLAGS +: NDSFLAGS];
        win_tag       = core_tag_i[c*WTAG +: WTAG];
      end
    end
  end

  assign unit_valid_o = win_vld;

  // Priority moves just past the winner so a persistent requester waits its turn.
  always_comb begin
    ptr_d = ptr_q;
    if (win_vld) ptr_d = (win_idx == IDX_W'(NCORES-1)) ? '0 : win_idx + 1'b1;
  end

  // Tag pipeline: stage 0 captures the grant, every stage shifts each cycle.
  always_comb begin
    pipe_d = '0;
    if (win_vld) begin
      pipe_d[0].vld = 1'b1;
      pipe_d[0].idx = win_idx;
      pipe_d[0].tag = win_tag;
    end
    for (int s = 1; s < PIPE_REGS; s++) pipe_d[s] = pipe_q[s-1];
  end

  // State registers; reset drops all in-flight tags and rewinds the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      pipe_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      pipe_q <= pipe_d;
    end
  end

  assign out_stg = pipe_q[PIPE_REGS-1];

  // Last stage lines up with the unit output: steer rvalid to the issuing core.
  always_comb begin
    core_rvalid_o = '0;
    for (int c = 0; c < NCORES; c++)
      if (out_stg.vld && out_stg.idx == IDX_W'(c)) core_rvalid_o[c] = 1'b1;
  end

  assign core_rtag_o   = out_stg.tag;
  assign core_result_o = unit_result_i;
  assign core_flags_o  = unit_flags_i;

  // Occupancy is the number of valid stages, output stage included.
  always_comb begin
    inflight_o = '0;
    for (int s = 0; s < PIPE_REGS; s++) inflight_o = inflight_o + CNT_W'(pipe_q[s].vld);
  end

`ifdef APU_DISP_CONTENTION_EN
  logic [31:0] cont_q, cont_d;
  logic        multi_req;

  // Saturating count of cycles with two or more simultaneous requesters.
  always_comb begin
    multi_req = |(core_req_i & (core_req_i - 1'b1));
    cont_d    = cont_q;
    if (multi_req && cont_q != 32'hFFFF_FFFF) cont_d = cont_q + 32'd1;
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cont_q <= '0;
    else       cont_q <= cont_d;
  end

  assign contention_cnt_o = cont_q;
`else
  assign contention_cnt_o = '0;
`endif

endmodule

// File: tb/tb_apu_rr_dispatcher.sv
// Bench for apu_rr_dispatcher: two instances (PIPE_REGS=1 and 3) share inputs and
// are compared every cycle against a cycle-indexed schedule of expected returns.
module tb_apu_rr_dispatcher;
  localparam int NC = 8;
  localparam int NA = 2;
  localparam int WD = 32;
  localparam int DEPTH = 2100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i = 1'b1;
  logic [NC-1:0]     core_req_i = '0;
  logic [NC*1-1:0]   core_op_i = '0;
  logic [NC*NA*WD-1:0] core_args_i = '0;
  logic [NC*3-1:0]   core_flags_i = '0;
  logic [NC*2-1:0]   core_tag_i = '0;
  logic [WD-1:0]     unit_result_i = '0;
  logic [7:0]        unit_flags_i = '0;

  logic [NC-1:0] gnt1, rv1, gnt3, rv3;
  logic [WD-1:0] res1, res3;
  logic [7:0]    cfl1, cfl3;
  logic [1:0]    rt1, rt3;
  logic          uv1, uv3;
  logic [0:0]    uop1, uop3;
  logic [63:0]   uargs1, uargs3;
  logic [2:0]    ufl1, ufl3;
  logic [0:0]    inf1;
  logic [1:0]    inf3;
  logic [31:0]   cnt1, cnt3;

  apu_rr_dispatcher #(.NCORES(NC), .PIPE_REGS(1)) u_p1 (
    .clk_i(clk), .rst_i(rst_i), .core_req_i(core_req_i), .core_gnt_o(gnt1),
    .core_op_i(core_op_i), .core_args_i(core_args_i), .core_flags_i(core_flags_i),
    .core_tag_i(core_tag_i), .core_rvalid_o(rv1), .core_result_o(res1),
    .core_flags_o(cfl1), .core_rtag_o(rt1), .unit_valid_o(uv1), .unit_op_o(uop1),
    .unit_args_o(uargs1), .unit_flags_o(ufl1), .unit_result_i(unit_result_i),
    .unit_flags_i(unit_flags_i), .inflight_o(inf1), .contention_cnt_o(cnt1));

  apu_rr_dispatcher #(.NCORES(NC), .PIPE_REGS(3)) u_p3 (
    .clk_i(clk), .rst_i(rst_i), .core_req_i(core_req_i), .core_gnt_o(gnt3),
    .core_op_i(core_op_i), .core_args_i(core_args_i), .core_flags_i(core_flags_i),
    .core_tag_i(core_tag_i), .core_rvalid_o(rv3), .core_result_o(res3),
    .core_flags_o(cfl3), .core_rtag_o(rt3), .unit_valid_o(uv3), .unit_op_o(uop3),
    .unit_args_o(uargs3), .unit_flags_o(ufl3), .unit_result_i(unit_result_i),
    .unit_flags_i(unit_flags_i), .inflight_o(inf3), .contention_cnt_o(cnt3));

  int vectors = 0;
  int miscompares = 0;

  // Reference state: per-core operands, RR pointer, and the cycle at which each
  // granted op must come back (ret_core = -1 means nothing returns that cycle).
  logic [0:0]  op_a   [NC];
  logic [63:0] args_a [NC];
  logic [2:0]  fl_a   [NC];
  logic [1:0]  tag_a  [NC];
  int          ret_core [2][DEPTH];
  logic [1:0]  ret_tag  [2][DEPTH];
  int          ptr_m = 0;
  int          win_m;
  int          n = 0;
  logic [31:0] cnt_m = 0;
  bit          prev_rst = 1'b1;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc%0d: observed %0h expected %0h", nm, n, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [NC-1:0] gnt, input logic uv,
                           input logic [0:0] uop, input logic [63:0] uargs,
                           input logic [2:0] ufl, input logic [NC-1:0] rv,
                           input logic [1:0] rt, input logic [WD-1:0] res,
                           input logic [7:0] cfl, input int infl, input logic [31:0] cnt);
    logic [NC-1:0] eg, erv;
    int busy;
    string p;
    p = (d == 0) ? "p1" : "p3";
    eg = '0;
    if (win_m >= 0) eg[win_m] = 1'b1;
    erv = '0;
    if (ret_core[d][n] >= 0) erv[ret_core[d][n]] = 1'b1;
    busy = 0;
    for (int k = 0; k < lat(d); k++) if (ret_core[d][n+k] >= 0) busy++;
    chk({p, "_gnt"},    64'(gnt), 64'(eg));
    chk({p, "_uvalid"}, 64'(uv),  64'(win_m >= 0));
    chk({p, "_uop"},    64'(uop), (win_m >= 0) ? 64'(op_a[win_m]) : 64'd0);
    chk({p, "_uargs"},  uargs,    (win_m >= 0) ? args_a[win_m] : 64'd0);
    chk({p, "_uflags"}, 64'(ufl), (win_m >= 0) ? 64'(fl_a[win_m]) : 64'd0);
    chk({p, "_rvalid"}, 64'(rv),  64'(erv));
    if (ret_core[d][n] >= 0) chk({p, "_rtag"}, 64'(rt), 64'(ret_tag[d][n]));
    else if (prev_rst)       chk({p, "_rtag_rst"}, 64'(rt), 64'd0);
    chk({p, "_result"}, 64'(res), 64'(unit_result_i));
    chk({p, "_cflags"}, 64'(cfl), 64'(unit_flags_i));
    chk({p, "_inflight"}, 64'(infl), 64'(busy));
    chk({p, "_contention"}, 64'(cnt), 64'(cnt_m));
  endtask

  // One clock cycle: drive, let combinational paths settle, compare, advance model.
  task automatic step(input logic [NC-1:0] req, input logic r, input bit rnd);
    @(posedge clk); #1;
    if (rnd)
      for (int c = 0; c < NC; c++) begin
        op_a[c]   = 1'($urandom);
        args_a[c] = {$urandom, $urandom};
        fl_a[c]   = 3'($urandom);
        tag_a[c]  = 2'($urandom);
      end
    for (int c = 0; c < NC; c++) begin
      core_op_i[c]               = op_a[c];
      core_args_i[c*64 +: 64]    = args_a[c];
      core_flags_i[c*3 +: 3]     = fl_a[c];
      core_tag_i[c*2 +: 2]       = tag_a[c];
    end
    core_req_i    = req;
    rst_i         = r;
    unit_result_i = $urandom;
    unit_flags_i  = 8'($urandom);
    #3;
    win_m = -1;
    if (!r)
      for (int k = 0; k < NC; k++)
        if (win_m < 0 && req[(ptr_m + k) % NC]) win_m = (ptr_m + k) % NC;
    check_dut(0, gnt1, uv1, uop1, uargs1, ufl1, rv1, rt1, res1, cfl1, int'(inf1), cnt1);
    check_dut(1, gnt3, uv3, uop3, uargs3, ufl3, rv3, rt3, res3, cfl3, int'(inf3), cnt3);
    if (r) begin
      for (int m = n + 1; m < DEPTH; m++) begin
        ret_core[0][m] = -1;
        ret_core[1][m] = -1;
      end
      ptr_m = 0;
      cnt_m = 0;
    end else begin
      if (win_m >= 0) begin
        for (int d = 0; d < 2; d++) begin
          ret_core[d][n + lat(d)] = win_m;
          ret_tag[d][n + lat(d)]  = tag_a[win_m];
        end
        ptr_m = (win_m + 1) % NC;
      end
`ifdef APU_DISP_CONTENTION_EN
      if ($countones(req) >= 2 && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
`endif
    end
    prev_rst = r;
    n++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < DEPTH; m++) begin
        ret_core[d][m] = -1;
        ret_tag[d][m]  = '0;
      end
    for (int c = 0; c < NC; c++) begin
      op_a[c] = '0; args_a[c] = '0; fl_a[c] = '0; tag_a[c] = '0;
    end

    // Reset with requests pending: no grant, outputs at reset values.
    step(8'hFF, 1'b1, 1'b1);
    step(8'hFF, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Single requester: core 3, tag 2'b10, operands 1.0 and 2.0.
    op_a[3]   = 1'b1;
    args_a[3] = {32'h4000_0000, 32'h3F80_0000};
    fl_a[3]   = 3'b001;
    tag_a[3]  = 2'b10;
    step(8'h08, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);

    // All cores request continuously from reset: strict 0..7 rotation.
    step(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) step(8'hFF, 1'b0, 1'b1);

    // Pointer wrap: core 6 moves ptr to 7, then 7/0 contend, 7 drops.
    step(8'h00, 1'b1, 1'b1);
    step(8'h40, 1'b0, 1'b1);
    step(8'h81, 1'b0, 1'b1);
    step(8'h01, 1'b0, 1'b1);
    step(8'h03, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);

    // Back-to-back single grants to cores 1, 5, 2.
    step(8'h02, 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b1);
    step(8'h04, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1);

    // Reset one cycle after a grant: the in-flight result must vanish.
    step(8'h10, 1'b0, 1'b1);
    step(8'h18, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1);

    // Contention: two requesters for 10 cycles, then one for 5.
    step(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(8'h44, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)  step(8'h04, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++)
      step(8'($urandom) & 8'($urandom), ($urandom_range(0, 39) == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
